commit_trace_monitor: RTL and testbench

// Synthesizable, pipeline-aware retirement monitor at the CPU writeback/commit point.

---
 rtl/trace_pkg.sv | 44 ++++
 rtl/sync_fifo.sv | 44 ++++
 rtl/commit_trace_monitor.sv | 153 +++++++++++++++
 tb/tb_commit_trace_monitor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the commit trace monitor: record kinds, record layout, FSM states.
// Latency: n/a (types and a pure classification function only).
// Backpressure: n/a.
package trace_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_PC_W   = 16;
  localparam int DEF_REG_W  = 4;
  localparam int DEF_CNT_W  = 32;

  typedef enum logic [2:0] {
    KIND_REG   = 3'd0,
    KIND_LOAD  = 3'd1,
    KIND_STORE = 3'd2,
    KIND_NOP   = 3'd3,
    KIND_HALT  = 3'd4
  } traceKind_t;

  typedef struct packed {
    traceKind_t              kind;
    logic [DEF_CNT_W-1:0]    inum;
    logic [DEF_PC_W-1:0]     pc;
    logic [DEF_REG_W-1:0]    regIdx;
    logic [DEF_DATA_W-1:0]   val;
    logic [DEF_PC_W-1:0]     addr;
  } traceRec_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } monState_t;

  // Halt dominates; a register write with a load is a LOAD; stores without writeback are STORE.
  function automatic traceKind_t classifyKind(input logic halt, input logic regWe,
                                              input logic memRe, input logic memWe);
    if (halt) return KIND_HALT;
    if (regWe) return memRe ? KIND_LOAD : KIND_REG;
    if (memWe) return KIND_STORE;
    return KIND_NOP;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers to tell full from empty.
// Latency: a write is visible at rdData on the cycle after it is accepted.
// Backpressure: caller must not write when full (unless reading) nor read when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrData,
  input  logic             rdEn,
  output logic [WIDTH-1:0] rdData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign rdData = mem[rdPtr[AW-1:0]];

  // Pointer advance; reset discards all stored entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (rdEn) rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage write; a write into the slot being popped lands after the pop reads it.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr[AW-1:0]] <= wrData;
  end

endmodule

// File: rtl/commit_trace_monitor.sv
// Retirement monitor: classifies commits into trace records, counts, detects halt/watchdog.
// Latency: a record accepted in cycle N is at the FIFO head in cycle N+1 when the FIFO was empty.
// Backpressure: trc_ready stalls the head; a commit arriving to a full, non-popping FIFO is dropped and counted.
module commit_trace_monitor
  import trace_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int PC_W        = DEF_PC_W,
  parameter int REG_W       = DEF_REG_W,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CYCLE_LIMIT = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cm_valid,
  input  logic              cm_flush,
  input  logic [PC_W-1:0]   cm_pc,
  input  logic              cm_reg_we,
  input  logic [REG_W-1:0]  cm_reg_idx,
  input  logic [DATA_W-1:0] cm_reg_data,
  input  logic              cm_mem_re,
  input  logic              cm_mem_we,
  input  logic [PC_W-1:0]   cm_mem_addr,
  input  logic [DATA_W-1:0] cm_mem_data,
  input  logic              cm_halt,
  output logic              trc_valid,
  input  logic              trc_ready,
  output logic [2:0]        trc_kind,
  output logic [CNT_W-1:0]  trc_inum,
  output logic [PC_W-1:0]   trc_pc,
  output logic [REG_W-1:0]  trc_reg,
  output logic [DATA_W-1:0] trc_val,
  output logic [PC_W-1:0]   trc_addr,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow,
  output logic              halted,
  output logic              done,
  output logic              timeout
);

  localparam int REC_W = $bits(traceRec_t);

  monState_t        state;
  monState_t        stateNext;
  traceRec_t        newRec;
  traceRec_t        headRec;
  logic [REC_W-1:0] headBits;
  logic             accept;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             pop;
  logic             push;
  logic             drop;

  assign accept = cm_valid && !cm_flush && (state == ST_RUN);
  assign pop    = !fifoEmpty && trc_ready;
  // A full FIFO still takes the record when the head leaves in the same cycle.
  assign push   = accept && (!fifoFull || pop);
  assign drop   = accept && fifoFull && !pop;

  // Build the trace record; fields not meaningful for the kind stay zero.
  always_comb begin
    newRec      = '0;
    newRec.kind = classifyKind(cm_halt, cm_reg_we, cm_mem_re, cm_mem_we);
    newRec.inum = inst_count;
    newRec.pc   = cm_pc;
    case (newRec.kind)
      KIND_REG: begin
        newRec.regIdx = cm_reg_idx;
        newRec.val    = cm_reg_data;
      end
      KIND_LOAD: begin
        newRec.regIdx = cm_reg_idx;
        newRec.val    = cm_reg_data;
        newRec.addr   = cm_mem_addr;
      end
      KIND_STORE: begin
        newRec.val  = cm_mem_data;
        newRec.addr = cm_mem_addr;
      end
      default: ;
    endcase
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) recFifo (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (push),
    .wrData (newRec),
    .rdEn   (pop),
    .rdData (headBits),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  assign headRec = headBits;

  // Instruction, cycle and drop counters plus the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_count  <= '0;
      cycle_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (accept) inst_count <= inst_count + 1'b1;
      if (state == ST_RUN && cycle_count != {CNT_W{1'b1}}) cycle_count <= cycle_count + 1'b1;
      if (drop) begin
        drop_count <= drop_count + 1'b1;
        overflow   <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= stateNext;
  end

  // FSM next state: halt beats the watchdog; DONE and TIMEOUT are terminal.
  always_comb begin
    stateNext = state;
    case (state)
      ST_RUN: begin
        if (accept && cm_halt)                          stateNext = ST_DRAIN;
        else if (cycle_count == CNT_W'(CYCLE_LIMIT - 1)) stateNext = ST_TIMEOUT;
      end
      ST_DRAIN: if (fifoEmpty) stateNext = ST_DONE;
      default: ;
    endcase
  end

  // Head fields are zeroed while the FIFO is empty so idle outputs read as 0.
  assign trc_valid = !fifoEmpty;
  assign trc_kind  = trc_valid ? headRec.kind   : 3'd0;
  assign trc_inum  = trc_valid ? headRec.inum   : '0;
  assign trc_pc    = trc_valid ? headRec.pc     : '0;
  assign trc_reg   = trc_valid ? headRec.regIdx : '0;
  assign trc_val   = trc_valid ? headRec.val    : '0;
  assign trc_addr  = trc_valid ? headRec.addr   : '0;

  assign halted  = (state == ST_DRAIN) || (state == ST_DONE);
  assign done    = (state == ST_DONE) || (state == ST_DRAIN && fifoEmpty);
  assign timeout = (state == ST_TIMEOUT);

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Directed bench for commit_trace_monitor: classification, flush, overflow, halt drain, watchdog.
// Latency: inputs change 1ns after posedge; status is read 1ns after posedge, records captured at negedge.
// Backpressure: trc_ready driven by the bench to exercise stall, drop and same-cycle push/pop.
module tb_commit_trace_monitor;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [15:0] val;
    logic [15:0] addr;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cm_valid = 0, cm_flush = 0, cm_reg_we = 0, cm_mem_re = 0, cm_mem_we = 0, cm_halt = 0;
  logic [15:0] cm_pc = 0, cm_reg_data = 0, cm_mem_addr = 0, cm_mem_data = 0;
  logic [3:0]  cm_reg_idx = 0;
  logic        trc_ready = 0;

  logic        trc_valid, overflow, halted, done, timeout;
  logic [2:0]  trc_kind;
  logic [31:0] trc_inum, inst_count, cycle_count, drop_count;
  logic [15:0] trc_pc, trc_val, trc_addr;
  logic [3:0]  trc_reg;

  logic        validB, overflowB, haltedB, doneB, timeoutB;
  logic [2:0]  kindB;
  logic [31:0] inumB, instB, cycleB, dropB;
  logic [15:0] pcB, valB, addrB;
  logic [3:0]  regB;

  int   checks = 0;
  int   failures = 0;
  rec_t gotQ[$];

  always #5 clk = ~clk;

  commit_trace_monitor dutA (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_flush(cm_flush), .cm_pc(cm_pc),
    .cm_reg_we(cm_reg_we), .cm_reg_idx(cm_reg_idx), .cm_reg_data(cm_reg_data),
    .cm_mem_re(cm_mem_re), .cm_mem_we(cm_mem_we), .cm_mem_addr(cm_mem_addr),
    .cm_mem_data(cm_mem_data), .cm_halt(cm_halt), .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_kind(trc_kind), .trc_inum(trc_inum), .trc_pc(trc_pc), .trc_reg(trc_reg),
    .trc_val(trc_val), .trc_addr(trc_addr), .inst_count(inst_count), .cycle_count(cycle_count),
    .drop_count(drop_count), .overflow(overflow), .halted(halted), .done(done), .timeout(timeout)
  );

  commit_trace_monitor #(.CYCLE_LIMIT(20)) dutB (
    .clk(clk), .rst(rst), .cm_valid(cm_valid), .cm_flush(cm_flush), .cm_pc(cm_pc),
    .cm_reg_we(cm_reg_we), .cm_reg_idx(cm_reg_idx), .cm_reg_data(cm_reg_data),
    .cm_mem_re(cm_mem_re), .cm_mem_we(cm_mem_we), .cm_mem_addr(cm_mem_addr),
    .cm_mem_data(cm_mem_data), .cm_halt(cm_halt), .trc_valid(validB), .trc_ready(trc_ready),
    .trc_kind(kindB), .trc_inum(inumB), .trc_pc(pcB), .trc_reg(regB),
    .trc_val(valB), .trc_addr(addrB), .inst_count(instB), .cycle_count(cycleB),
    .drop_count(dropB), .overflow(overflowB), .halted(haltedB), .done(doneB), .timeout(timeoutB)
  );

  // Capture every record that will be handed off at the coming posedge.
  always @(negedge clk) begin
    if (!rst && trc_valid && trc_ready)
      gotQ.push_back('{trc_kind, trc_inum, trc_pc, trc_reg, trc_val, trc_addr});
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    {cm_valid, cm_flush, cm_reg_we, cm_mem_re, cm_mem_we, cm_halt} = '0;
    cm_pc = 0; cm_reg_idx = 0; cm_reg_data = 0; cm_mem_addr = 0; cm_mem_data = 0;
  endtask

  task automatic doReset();
    clearIn();
    trc_ready = 0;
    rst = 1;
    step();
    step();
    rst = 0;
    gotQ.delete();
  endtask

  task automatic setCommit(input logic halt, input logic regWe, input logic memRe, input logic memWe,
                           input logic [15:0] pc, input logic [3:0] idx, input logic [15:0] rdata,
                           input logic [15:0] addr, input logic [15:0] mdata);
    cm_valid = 1; cm_flush = 0;
    cm_halt = halt; cm_reg_we = regWe; cm_mem_re = memRe; cm_mem_we = memWe;
    cm_pc = pc; cm_reg_idx = idx; cm_reg_data = rdata; cm_mem_addr = addr; cm_mem_data = mdata;
  endtask

  initial begin
    int lastPop;
    int doneAt;
    logic popNow;

    // Reset state.
    doReset();
    checkVal("rst_valid", trc_valid, 0);
    checkVal("rst_kind_inum", {trc_kind, trc_inum}, 0);
    checkVal("rst_counts", {inst_count, cycle_count}, 0);
    checkVal("rst_flags", {drop_count, overflow, halted, done, timeout}, 0);

    // REG, LOAD, STORE with the sink always ready; unused fields must read 0.
    trc_ready = 1;
    setCommit(0, 1, 0, 0, 16'h0100, 4'd1, 16'h0005, 16'h0099, 16'h7777);
    step();
    checkVal("lat_valid", trc_valid, 1);
    checkVal("lat_inum", trc_inum, 0);
    setCommit(0, 1, 1, 0, 16'h0102, 4'd2, 16'h1234, 16'h0040, 16'h0000);
    step();
    setCommit(0, 0, 0, 1, 16'h0104, 4'd7, 16'h5555, 16'h0010, 16'h00AA);
    step();
    clearIn();
    repeat (3) step();
    checkVal("t1_count", gotQ.size(), 3);
    if (gotQ.size() == 3) begin
      checkVal("t1_reg", {gotQ[0].kind, gotQ[0].inum, gotQ[0].pc, gotQ[0].rg, gotQ[0].val, gotQ[0].addr},
               {3'd0, 32'd0, 16'h0100, 4'd1, 16'h0005, 16'h0000});
      checkVal("t1_load", {gotQ[1].kind, gotQ[1].inum, gotQ[1].pc, gotQ[1].rg, gotQ[1].val, gotQ[1].addr},
               {3'd1, 32'd1, 16'h0102, 4'd2, 16'h1234, 16'h0040});
      checkVal("t1_store", {gotQ[2].kind, gotQ[2].inum, gotQ[2].pc, gotQ[2].rg, gotQ[2].val, gotQ[2].addr},
               {3'd2, 32'd2, 16'h0104, 4'd0, 16'h00AA, 16'h0010});
    end
    checkVal("t1_inst", inst_count, 3);

    // Flushed commits produce nothing; a bare commit is a NOP.
    gotQ.delete();
    setCommit(0, 1, 0, 0, 16'h0200, 4'd3, 16'h0033, 16'h0000, 16'h0000);
    cm_flush = 1;
    step();
    step();
    clearIn();
    step();
    checkVal("flush_recs", gotQ.size(), 0);
    checkVal("flush_inst", inst_count, 3);
    setCommit(0, 0, 0, 0, 16'h0206, 4'd5, 16'h0011, 16'h0022, 16'h0033);
    step();
    clearIn();
    step();
    step();
    checkVal("nop_count", gotQ.size(), 1);
    if (gotQ.size() == 1)
      checkVal("nop_rec", {gotQ[0].kind, gotQ[0].inum, gotQ[0].pc, gotQ[0].rg, gotQ[0].val, gotQ[0].addr},
               {3'd3, 32'd3, 16'h0206, 4'd0, 16'h0000, 16'h0000});

    // Overflow: 10 commits into an 8-deep FIFO with the sink stalled.
    doReset();
    for (int i = 0; i < 10; i++) begin
      setCommit(0, 1, 0, 0, 16'h0300 + 16'(i), 4'(i), 16'(i), 16'h0000, 16'h0000);
      step();
    end
    clearIn();
    step();
    checkVal("ovf_drop", drop_count, 2);
    checkVal("ovf_flag", overflow, 1);
    checkVal("ovf_inst", inst_count, 10);
    checkVal("ovf_head_held", {trc_valid, trc_inum, trc_pc}, {1'b1, 32'd0, 16'h0300});

    // Full FIFO with push and pop together: no drop, occupancy remains 8.
    trc_ready = 1;
    setCommit(0, 1, 0, 0, 16'h03AA, 4'd10, 16'h000A, 16'h0000, 16'h0000);
    step();
    trc_ready = 0;
    clearIn();
    step();
    checkVal("pp_drop", drop_count, 2);
    trc_ready = 1;
    repeat (10) step();
    checkVal("pp_total", gotQ.size(), 9);
    if (gotQ.size() == 9) begin
      checkVal("pp_inum7", gotQ[7].inum, 7);
      checkVal("pp_last", {gotQ[8].inum, gotQ[8].pc}, {32'd10, 16'h03AA});
    end

    // HALT at inum 4 with ready toggling; commits after it are ignored.
    doReset();
    for (int i = 0; i < 7; i++) begin
      trc_ready = i[0];
      setCommit(i == 4, 1, 0, 0, 16'h0400 + 16'(i), 4'(i), 16'(i), 16'h0000, 16'h0000);
      step();
    end
    clearIn();
    checkVal("halt_flag", halted, 1);
    checkVal("halt_inst", inst_count, 5);
    checkVal("halt_cycle", cycle_count, 5);
    lastPop = -1;
    doneAt = -1;
    for (int k = 0; k < 40; k++) begin
      trc_ready = k[0];
      popNow = trc_valid && trc_ready;
      if (done && doneAt < 0 && trc_valid) begin
        checkVal("done_early", done, 0);
      end
      step();
      if (popNow) lastPop = k;
      if (done && doneAt < 0) doneAt = k;
    end
    // done is seen right after the edge that performed the final pop, i.e. the next cycle.
    checkVal("done_seen", doneAt >= 0, 1);
    checkVal("done_lat", doneAt - lastPop, 0);
    checkVal("halt_recs", gotQ.size(), 5);
    if (gotQ.size() == 5)
      checkVal("halt_rec", {gotQ[4].kind, gotQ[4].inum, gotQ[4].pc}, {3'd4, 32'd4, 16'h0404});
    checkVal("halt_frozen", {cycle_count, inst_count}, {32'd5, 32'd5});

    // Watchdog with CYCLE_LIMIT=20.
    doReset();
    repeat (19) step();
    checkVal("wd_pre", {timeoutB, cycleB}, {1'b0, 32'd19});
    step();
    checkVal("wd_fire", {timeoutB, cycleB}, {1'b1, 32'd20});
    setCommit(0, 1, 0, 0, 16'h0500, 4'd1, 16'h0001, 16'h0000, 16'h0000);
    step();
    clearIn();
    step();
    checkVal("wd_ignored", {instB, cycleB, validB}, {32'd0, 32'd20, 1'b0});

    // HALT in the expiry cycle: halt wins.
    doReset();
    trc_ready = 1;
    repeat (19) step();
    setCommit(1, 0, 0, 0, 16'h0600, 4'd0, 16'h0000, 16'h0000, 16'h0000);
    step();
    clearIn();
    checkVal("wd_halt_wins", {haltedB, timeoutB, cycleB}, {1'b1, 1'b0, 32'd20});
    step();
    step();
    checkVal("wd_halt_done", doneB, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
